// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed two-digit seven-segment bus and recovers the hex value
// being displayed. Each digit is accepted only after its select/segment pattern
// has been stable for SETTLE cycles. Two accepted digits form a frame, which
// updates value/dp/bad and pulses frame_valid. A long gap with no accepted
// digit raises blank.

module seg7_scan_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int SETTLE         = 16,
  parameter int TIMEOUT        = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cs,
  input  logic [7:0] dx,
  output logic [7:0] value,
  output logic [1:0] dp,
  output logic [1:0] bad,
  output logic       frame_valid,
  output logic       changed,
  output logic       blank,
  output logic       cs_err
);

  // Stability counter: wide enough to hold SETTLE-1, where it saturates.
  localparam int CNT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(SETTLE - 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT);

  // Synchronizer reset values: select idle (both high), segments zero.
  localparam logic [1:0] CS_IDLE = 2'b11;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Input synchronizers.
  logic [1:0]       cs_meta_q, cs_sync_q;
  logic [7:0]       dx_meta_q, dx_sync_q;

  // Stability tracking and FSM.
  logic [9:0]       pat_prev_q, pat_prev_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  state_t           state_q, state_d;

  // Per-digit staging.
  logic [1:0][3:0]  stage_nib_q, stage_nib_d;
  logic [1:0]       stage_dp_q, stage_dp_d;
  logic [1:0]       stage_bad_q, stage_bad_d;
  logic [1:0]       have_q, have_d;

  // Registered outputs.
  logic [7:0]       value_q, value_d;
  logic [1:0]       dp_q, dp_d;
  logic [1:0]       bad_q, bad_d;
  logic             frame_valid_q, frame_valid_d;
  logic             changed_q, changed_d;
  logic             blank_q, blank_d;
  logic             cs_err_q, cs_err_d;

  // Timeout tracking.
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  // Combinational helpers.
  logic [9:0]       pat_now;
  logic             pat_same;
  logic [7:0]       dx_lit;
  logic [4:0]       glyph;
  logic             sel_d0, sel_d1;
  logic             capture;
  logic [1:0]       have_next;

  // Maps a lit=1 segment pattern (g..a) to {bad, nibble}; unknown patterns give bad=1, nibble=0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    res = {1'b1, 4'h0};
    case (seg)
      7'h3F: res = {1'b0, 4'h0};
      7'h06: res = {1'b0, 4'h1};
      7'h5B: res = {1'b0, 4'h2};
      7'h4F: res = {1'b0, 4'h3};
      7'h66: res = {1'b0, 4'h4};
      7'h6D: res = {1'b0, 4'h5};
      7'h7D: res = {1'b0, 4'h6};
      7'h07: res = {1'b0, 4'h7};
      7'h7F: res = {1'b0, 4'h8};
      7'h6F: res = {1'b0, 4'h9};
      7'h77: res = {1'b0, 4'hA};
      7'h7C: res = {1'b0, 4'hB};
      7'h39: res = {1'b0, 4'hC};
      7'h5E: res = {1'b0, 4'hD};
      7'h79: res = {1'b0, 4'hE};
      7'h71: res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  // Normalise the synced segments to lit=1, decode them, and decide whether this cycle captures a digit.
  always_comb begin
    pat_now  = {cs_sync_q, dx_sync_q};
    pat_same = (pat_now == pat_prev_q);
    dx_lit   = SEG_ACTIVE_LOW ? ~dx_sync_q : dx_sync_q;
    glyph    = decode_glyph(dx_lit[6:0]);
    sel_d0   = (cs_sync_q == 2'b10);
    sel_d1   = (cs_sync_q == 2'b01);
    // The counter reaches SETTLE-1 on this edge, so the digit is taken now.
    capture  = (state_q == S_WAIT) && pat_same && (stab_cnt_q == CNT_CAPTURE)
               && (sel_d0 || sel_d1);
    have_next = have_q | {sel_d1 & capture, sel_d0 & capture};
  end

  // Next-state logic for stability tracking, staging, frame assembly and timeout.
  always_comb begin
    pat_prev_d    = pat_now;
    stab_cnt_d    = stab_cnt_q;
    state_d       = state_q;
    stage_nib_d   = stage_nib_q;
    stage_dp_d    = stage_dp_q;
    stage_bad_d   = stage_bad_q;
    have_d        = have_q;
    value_d       = value_q;
    dp_d          = dp_q;
    bad_d         = bad_q;
    frame_valid_d = 1'b0;
    changed_d     = 1'b0;
    blank_d       = blank_q;
    cs_err_d      = 1'b0;
    to_cnt_d      = to_cnt_q;

    // Any change of select or segments restarts the settle window.
    if (!pat_same) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != CNT_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_WAIT: if (capture) state_d = S_HOLD;
      S_HOLD: if (!pat_same) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase

    // Both digits selected at once is a driver fault; flag it once per entry.
    cs_err_d = (cs_sync_q == 2'b00) && (pat_prev_q[9:8] != 2'b00);

    if (capture) begin
      if (sel_d0) begin
        stage_nib_d[0] = glyph[3:0];
        stage_dp_d[0]  = dx_lit[7];
        stage_bad_d[0] = glyph[4];
      end else begin
        stage_nib_d[1] = glyph[3:0];
        stage_dp_d[1]  = dx_lit[7];
        stage_bad_d[1] = glyph[4];
      end

      if (&have_next) begin
        value_d       = {stage_nib_d[1], stage_nib_d[0]};
        dp_d          = stage_dp_d;
        bad_d         = stage_bad_d;
        frame_valid_d = 1'b1;
        changed_d     = ({value_d, dp_d, bad_d} != {value_q, dp_q, bad_q});
        have_d        = '0;
      end else begin
        have_d = have_next;
      end

      // A capture always restarts the timeout, even on the expiry cycle.
      to_cnt_d = '0;
      blank_d  = 1'b0;
    end else begin
      if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
      blank_d = blank_q | (to_cnt_d == TO_MAX);
    end
  end

  // State registers, including the two-flop input synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q     <= CS_IDLE;
      cs_sync_q     <= CS_IDLE;
      dx_meta_q     <= '0;
      dx_sync_q     <= '0;
      pat_prev_q    <= {CS_IDLE, 8'h00};
      stab_cnt_q    <= '0;
      state_q       <= S_WAIT;
      stage_nib_q   <= '0;
      stage_dp_q    <= '0;
      stage_bad_q   <= '0;
      have_q        <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      bad_q         <= '0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      blank_q       <= 1'b1;
      cs_err_q      <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      cs_meta_q     <= cs;
      cs_sync_q     <= cs_meta_q;
      dx_meta_q     <= dx;
      dx_sync_q     <= dx_meta_q;
      pat_prev_q    <= pat_prev_d;
      stab_cnt_q    <= stab_cnt_d;
      state_q       <= state_d;
      stage_nib_q   <= stage_nib_d;
      stage_dp_q    <= stage_dp_d;
      stage_bad_q   <= stage_bad_d;
      have_q        <= have_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      bad_q         <= bad_d;
      frame_valid_q <= frame_valid_d;
      changed_q     <= changed_d;
      blank_q       <= blank_d;
      cs_err_q      <= cs_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign bad         = bad_q;
  assign frame_valid = frame_valid_q;
  assign changed     = changed_q;
  assign blank       = blank_q;
  assign cs_err      = cs_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Drives directed scan sequences on a common-anode bus and compares every
// frame against hand-computed expectations held in a scoreboard queue.

module tb_seg7_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int TO_W    = 10;
  localparam int LAT     = 2 + SETTLE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cs = 2'b11;
  logic [7:0] dx = 8'hFF;
  logic [7:0] value;
  logic [1:0] dp;
  logic [1:0] bad;
  logic       frame_valid;
  logic       changed;
  logic       blank;
  logic       cs_err;

  typedef struct {
    logic [7:0] value;
    logic [1:0] dp;
    logic [1:0] bad;
    logic       changed;
    int         at_cyc;
  } frame_t;

  frame_t exp_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int frames_seen = 0;
  int cs_err_seen = 0;
  int drive_cyc = 0;
  int last_cap = 0;
  int f_mark = 0;

  seg7_scan_decoder #(
    .SEG_ACTIVE_LOW(1'b1),
    .SETTLE(SETTLE),
    .TIMEOUT(TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs(cs),
    .dx(dx),
    .value(value),
    .dp(dp),
    .bad(bad),
    .frame_valid(frame_valid),
    .changed(changed),
    .blank(blank),
    .cs_err(cs_err)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Edge counter used to time captures and the timeout.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Sets the pins; callers are aligned just after a rising edge.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d);
    cs = c;
    dx = d;
    drive_cyc = cyc;
  endtask

  task automatic holdFor(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scanDigit(input logic [1:0] c, input logic [7:0] d, input int n);
    applyStimulus(c, d);
    holdFor(n);
  endtask

  // Frame expected on the capture edge of the pattern just applied.
  task automatic expectFrame(input logic [7:0] v, input logic [1:0] p, input logic [1:0] b, input logic ch);
    frame_t e;
    e.value   = v;
    e.dp      = p;
    e.bad     = b;
    e.changed = ch;
    e.at_cyc  = drive_cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Moves to the falling edge where the cycle counter equals target.
  task automatic waitCycle(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < target && guard < 5000);
    if (cyc != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cycle: got %0d, expected %0d", cyc, target);
    end
  endtask

  // Scoreboard monitor: pops one expectation per frame_valid pulse.
  always @(negedge clk) begin : monitor
    frame_t e;
    if (cs_err) cs_err_seen++;
    if (frame_valid) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame: got value=%0h at cycle %0d, expected no frame", value, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_value", 32'(value), 32'(e.value));
        checkOutput("frame_dp", 32'(dp), 32'(e.dp));
        checkOutput("frame_bad", 32'(bad), 32'(e.bad));
        checkOutput("frame_changed", 32'(changed), 32'(e.changed));
        checkOutput("frame_cycle", cyc, e.at_cyc);
      end
    end
  end

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    holdFor(3);
    checkOutput("por_value", 32'(value), 32'h00);
    checkOutput("por_dp", 32'(dp), 32'h0);
    checkOutput("por_bad", 32'(bad), 32'h0);
    checkOutput("por_blank", 32'(blank), 32'h1);
    checkOutput("por_frame_valid", 32'(frame_valid), 32'h0);
    checkOutput("por_changed", 32'(changed), 32'h0);
    checkOutput("por_cs_err", 32'(cs_err), 32'h0);
    rst_n = 1'b1;
    holdFor(1);

    // First frame: digit0 shows 0 (C0), digit1 shows 1 (F9).
    scanDigit(2'b10, 8'hC0, 100);
    applyStimulus(2'b01, 8'hF9);
    expectFrame(8'h10, 2'b00, 2'b00, 1'b1);
    holdFor(100);
    checkOutput("blank_after_scan", 32'(blank), 32'h0);

    // Same frame again is not a change; then digit1 shows 8 with its dp lit.
    scanDigit(2'b10, 8'hC0, 100);
    applyStimulus(2'b01, 8'hF9);
    expectFrame(8'h10, 2'b00, 2'b00, 1'b0);
    holdFor(100);
    scanDigit(2'b10, 8'hC0, 100);
    applyStimulus(2'b01, 8'h00);
    expectFrame(8'h80, 2'b10, 2'b00, 1'b1);
    holdFor(100);

    // Reset mid-scan with digit1 already staged; the staged digit must be discarded.
    scanDigit(2'b01, 8'hF9, 100);
    applyStimulus(2'b10, 8'hC0);
    holdFor(5);
    rst_n = 1'b0;
    holdFor(3);
    checkOutput("rst_value", 32'(value), 32'h00);
    checkOutput("rst_dp", 32'(dp), 32'h0);
    checkOutput("rst_blank", 32'(blank), 32'h1);
    checkOutput("rst_frame_valid", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    f_mark = frames_seen;
    holdFor(SETTLE);
    checkOutput("blank_before_capture", 32'(blank), 32'h1);
    holdFor(SETTLE);
    checkOutput("no_frame_after_reset", frames_seen, f_mark);
    checkOutput("blank_after_capture", 32'(blank), 32'h0);
    holdFor(20);

    // A '2' held one cycle short of settling is skipped; the following '3' is staged.
    applyStimulus(2'b10, 8'hA4);
    holdFor(SETTLE - 1);
    applyStimulus(2'b10, 8'hB0);
    holdFor(SETTLE + 5);
    applyStimulus(2'b01, 8'hC0);
    expectFrame(8'h03, 2'b00, 2'b00, 1'b1);
    holdFor(100);

    // Segment a alone is not a glyph; then both selects low raises one cs_err.
    scanDigit(2'b10, 8'hFE, 100);
    applyStimulus(2'b01, 8'hC0);
    expectFrame(8'h00, 2'b00, 2'b01, 1'b1);
    last_cap = drive_cyc + LAT;
    holdFor(100);
    applyStimulus(2'b00, 8'hC0);
    holdFor(10);
    checkOutput("cs_err_pulses", cs_err_seen, 1);

    // Stop scanning: blank rises exactly TIMEOUT cycles after the last capture.
    applyStimulus(2'b11, 8'hFF);
    waitCycle(last_cap + TIMEOUT - 1);
    checkOutput("blank_before_timeout", 32'(blank), 32'h0);
    waitCycle(last_cap + TIMEOUT);
    checkOutput("blank_at_timeout", 32'(blank), 32'h1);
    checkOutput("held_value", 32'(value), 32'h00);
    checkOutput("held_bad", 32'(bad), 32'h1);
    holdFor(50);
    checkOutput("blank_stays", 32'(blank), 32'h1);

    // Resume: blank clears on the next capture edge.
    applyStimulus(2'b10, 8'hC0);
    waitCycle(drive_cyc + LAT - 1);
    checkOutput("blank_pre_resume", 32'(blank), 32'h1);
    waitCycle(drive_cyc + LAT);
    checkOutput("blank_resume", 32'(blank), 32'h0);
    holdFor(100);
    applyStimulus(2'b01, 8'hF9);
    expectFrame(8'h10, 2'b00, 2'b00, 1'b1);
    holdFor(100);

    checkOutput("pending_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
